out_port_fifo: RTL and testbench

Parametrised successor to the single-register output port of the datapath. It captures BusMuxOut whenever outPortEnable is asserted during an `out` instruction, and steers the word to one of NUM_CH output channels selected by the instruction. Each channel has its own DEPTH-entry first-word-fall-through FIFO and drains to an external device over a valid/ready handshake. Each channel keeps a "last delivered" register that gives the classic out-port view.

---
 rtl/out_port_fifo_if.sv | 42 ++++
 rtl/out_port_fifo.sv | 136 +++++++++++++
 tb/tb_out_port_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/out_port_fifo_if.sv
// ---------------------------------------------------------------------------
// out_port_fifo_if
// Bus-side and device-side signal bundle for out_port_fifo.
//   BusMuxOut      datapath word to be written
//   outPortEnable  write strobe (one push per asserted cycle)
//   ch_sel         target channel of the write
//   port_ready     per-channel device ready
//   port_valid     per-channel head word valid
//   port_data      per-channel head word, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   port_latched   per-channel last word accepted by the device
//   full / empty   per-channel FIFO status
//   overflow       per-channel sticky dropped-write flag
//   sel_err        sticky flag for writes to a non-existent channel
// master: datapath/device side, slave: the FIFO block.
// ---------------------------------------------------------------------------
interface out_port_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1
);
    logic [DATA_WIDTH-1:0]        BusMuxOut;
    logic                         outPortEnable;
    logic [CH_W-1:0]              ch_sel;
    logic [NUM_CH-1:0]            port_ready;
    logic [NUM_CH-1:0]            port_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] port_data;
    logic [NUM_CH*DATA_WIDTH-1:0] port_latched;
    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            empty;
    logic [NUM_CH-1:0]            overflow;
    logic                         sel_err;

    modport master (
        output BusMuxOut, outPortEnable, ch_sel, port_ready,
        input  port_valid, port_data, port_latched, full, empty, overflow, sel_err
    );

    modport slave (
        input  BusMuxOut, outPortEnable, ch_sel, port_ready,
        output port_valid, port_data, port_latched, full, empty, overflow, sel_err
    );
endinterface

// File: rtl/out_port_fifo.sv
// ---------------------------------------------------------------------------
// out_port_fifo
// Multi-channel output port. A bus word written with outPortEnable is steered
// by ch_sel into that channel's DEPTH-entry first-word-fall-through FIFO; each
// channel drains over its own valid/ready handshake and remembers the last
// word the device accepted (port_latched).
// Ports:
//   Clock  rising-edge system clock
//   Clear  synchronous active-high reset, dominates any push/pop
//   bus    out_port_fifo_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module out_port_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1
) (
    input  logic           Clock,
    input  logic           Clear,
    out_port_fifo_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // One extra bit so that the range check is never a constant comparison
    // when NUM_CH fills the whole ch_sel code space.
    logic [CH_W:0] sel_ext_s;
    logic          sel_bad_s;
    logic          sel_err_q;
    logic          sel_err_d;

    // Decode of writes aimed at a channel that does not exist.
    always_comb begin
        sel_ext_s = {1'b0, bus.ch_sel};
        sel_bad_s = bus.outPortEnable && (sel_ext_s >= (CH_W+1)'(NUM_CH));
        if (sel_bad_s) begin
            sel_err_d = 1'b1;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // Sticky invalid-select flag register.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.sel_err = sel_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      count_q, count_d;
        logic [DATA_WIDTH-1:0] latched_q, latched_d;
        logic                  overflow_q, overflow_d;
        logic                  hit_s, full_s, empty_s, push_s, pop_s, drop_s;
        logic [DATA_WIDTH-1:0] head_s;

        // Handshake decode and next-state for this channel. A push into a
        // full FIFO is accepted only when a pop frees a slot in the same cycle.
        always_comb begin
            hit_s   = bus.outPortEnable && (bus.ch_sel == CH_W'(g));
            full_s  = (count_q == CNT_W'(DEPTH));
            empty_s = (count_q == {CNT_W{1'b0}});
            head_s  = mem_q[rd_ptr_q];
            pop_s   = !empty_s && bus.port_ready[g];
            push_s  = hit_s && (!full_s || pop_s);
            drop_s  = hit_s && full_s && !pop_s;

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                latched_d = head_s;
            end else begin
                rd_ptr_d  = rd_ptr_q;
                latched_d = latched_q;
            end

            if (push_s && !pop_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end

            if (drop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end

        // Channel control registers; Clear flushes everything queued.
        always_ff @(posedge Clock) begin
            if (Clear) begin
                wr_ptr_q   <= {PTR_W{1'b0}};
                rd_ptr_q   <= {PTR_W{1'b0}};
                count_q    <= {CNT_W{1'b0}};
                latched_q  <= {DATA_WIDTH{1'b0}};
                overflow_q <= 1'b0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                latched_q  <= latched_d;
                overflow_q <= overflow_d;
            end
        end

        // Storage array; deliberately not reset, only written on accepted pushes.
        always_ff @(posedge Clock) begin
            if (push_s && !Clear) begin
                mem_q[wr_ptr_q] <= bus.BusMuxOut;
            end
        end

        assign bus.full[g]     = full_s;
        assign bus.empty[g]    = empty_s;
        assign bus.port_valid[g] = !empty_s;
        assign bus.overflow[g] = overflow_q;
        // Head word is forced to zero when nothing is queued.
        assign bus.port_data[g*DATA_WIDTH +: DATA_WIDTH]    = empty_s ? {DATA_WIDTH{1'b0}} : head_s;
        assign bus.port_latched[g*DATA_WIDTH +: DATA_WIDTH] = latched_q;
    end
endmodule

// File: tb/tb_out_port_fifo.sv
module tb_out_port_fifo;
    logic Clock;
    logic Clear;
    int   checks;
    int   failures;

    out_port_fifo_if #(.DATA_WIDTH(32), .NUM_CH(2), .CH_W(1)) bus2 ();
    out_port_fifo_if #(.DATA_WIDTH(32), .NUM_CH(3), .CH_W(2)) bus3 ();

    out_port_fifo #(.DATA_WIDTH(32), .DEPTH(4), .NUM_CH(2), .CH_W(1)) u_dut2 (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus2.slave)
    );

    out_port_fifo #(.DATA_WIDTH(32), .DEPTH(4), .NUM_CH(3), .CH_W(2)) u_dut3 (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus3.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ch2(input logic [63:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    function automatic logic [31:0] ch3(input logic [95:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with writes pending on both instances
        Clear              = 1'b1;
        bus2.outPortEnable = 1'b1;
        bus2.ch_sel        = 1'b0;
        bus2.BusMuxOut     = 32'h0000_0099;
        bus2.port_ready    = 2'b00;
        bus3.outPortEnable = 1'b1;
        bus3.ch_sel        = 2'd3;
        bus3.BusMuxOut     = 32'h0000_0077;
        bus3.port_ready    = 3'b000;
        step();
        step();
        check("rst_valid", bus2.port_valid, 2'b00);
        check("rst_empty", bus2.empty, 2'b11);
        check("rst_full", bus2.full, 2'b00);
        check("rst_ovf", bus2.overflow, 2'b00);
        check("rst_latched", bus2.port_latched, 64'h0);
        check("rst_data", bus2.port_data, 64'h0);
        check("rst_selerr3", bus3.sel_err, 1'b0);
        Clear              = 1'b0;
        bus2.outPortEnable = 1'b0;
        bus3.outPortEnable = 1'b0;
        step();
        check("rst_noword", bus2.empty, 2'b11);

        // Single write on ch1, then drain
        bus2.ch_sel        = 1'b1;
        bus2.BusMuxOut     = 32'h0000_00A5;
        bus2.outPortEnable = 1'b1;
        step();
        bus2.outPortEnable = 1'b0;
        check("single_valid", bus2.port_valid, 2'b10);
        check("single_data1", ch2(bus2.port_data, 1), 32'h0000_00A5);
        check("single_data0", ch2(bus2.port_data, 0), 32'h0);
        step();
        check("single_hold", ch2(bus2.port_data, 1), 32'h0000_00A5);
        bus2.port_ready = 2'b10;
        step();
        bus2.port_ready = 2'b00;
        check("single_drained", bus2.port_valid, 2'b00);
        check("single_latched", ch2(bus2.port_latched, 1), 32'h0000_00A5);

        // Fill ch0 and overflow it
        bus2.ch_sel        = 1'b0;
        bus2.outPortEnable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus2.BusMuxOut = 32'(k);
            step();
        end
        check("fill_full", bus2.full, 2'b01);
        check("fill_empty", bus2.empty, 2'b10);
        bus2.BusMuxOut = 32'd5;
        step();
        bus2.outPortEnable = 1'b0;
        check("ovf_flag", bus2.overflow, 2'b01);
        check("ovf_full", bus2.full, 2'b01);
        check("ovf_head", ch2(bus2.port_data, 0), 32'd1);
        bus2.port_ready = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            check("drain_head", ch2(bus2.port_data, 0), 32'(k));
            step();
            check("drain_latched", ch2(bus2.port_latched, 0), 32'(k));
        end
        bus2.port_ready = 2'b00;
        check("drain_empty", bus2.empty, 2'b11);
        check("drain_ovf_sticky", bus2.overflow, 2'b01);

        // Clear to drop sticky overflow, then push+pop on a full FIFO
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("clr_ovf", bus2.overflow, 2'b00);
        bus2.outPortEnable = 1'b1;
        for (int k = 10; k <= 13; k++) begin
            bus2.BusMuxOut = 32'(k);
            step();
        end
        check("pp_full", bus2.full, 2'b01);
        bus2.BusMuxOut  = 32'd14;
        bus2.port_ready = 2'b01;
        step();
        bus2.outPortEnable = 1'b0;
        bus2.port_ready    = 2'b00;
        check("pp_still_full", bus2.full, 2'b01);
        check("pp_no_ovf", bus2.overflow, 2'b00);
        check("pp_latched", ch2(bus2.port_latched, 0), 32'd10);
        check("pp_head", ch2(bus2.port_data, 0), 32'd11);
        bus2.port_ready = 2'b01;
        for (int k = 11; k <= 14; k++) begin
            check("wrap_head", ch2(bus2.port_data, 0), 32'(k));
            step();
            check("wrap_latched", ch2(bus2.port_latched, 0), 32'(k));
        end
        bus2.port_ready = 2'b00;
        check("wrap_empty", bus2.empty, 2'b11);

        // Invalid channel select on the three-channel instance
        bus3.ch_sel        = 2'd3;
        bus3.BusMuxOut     = 32'hDEAD_BEEF;
        bus3.outPortEnable = 1'b1;
        step();
        bus3.outPortEnable = 1'b0;
        check("sel_err", bus3.sel_err, 1'b1);
        check("sel_empty", bus3.empty, 3'b111);
        check("sel_valid", bus3.port_valid, 3'b000);
        check("sel_ovf", bus3.overflow, 3'b000);
        bus3.ch_sel        = 2'd2;
        bus3.BusMuxOut     = 32'h0000_0022;
        bus3.outPortEnable = 1'b1;
        step();
        bus3.outPortEnable = 1'b0;
        check("ch2_valid", bus3.port_valid, 3'b100);
        check("ch2_data", ch3(bus3.port_data, 2), 32'h0000_0022);
        check("sel_err_sticky", bus3.sel_err, 1'b1);

        // Clear mid-stream on ch1
        bus2.ch_sel        = 1'b1;
        bus2.BusMuxOut     = 32'h0000_0007;
        bus2.outPortEnable = 1'b1;
        step();
        bus2.outPortEnable = 1'b0;
        bus2.port_ready    = 2'b10;
        step();
        bus2.port_ready = 2'b00;
        check("mid_latched", ch2(bus2.port_latched, 1), 32'h0000_0007);
        bus2.outPortEnable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus2.BusMuxOut = 32'h30 + 32'(k);
            step();
        end
        bus2.outPortEnable = 1'b0;
        check("mid_valid", bus2.port_valid, 2'b10);
        check("mid_head", ch2(bus2.port_data, 1), 32'h0000_0031);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("mid_empty", bus2.empty, 2'b11);
        check("mid_valid0", bus2.port_valid, 2'b00);
        check("mid_latched0", bus2.port_latched, 64'h0);
        check("mid_ovf0", bus2.overflow, 2'b00);
        check("mid_selerr0", bus3.sel_err, 1'b0);
        bus2.BusMuxOut     = 32'h0000_0055;
        bus2.outPortEnable = 1'b1;
        step();
        bus2.outPortEnable = 1'b0;
        check("post_valid", bus2.port_valid, 2'b10);
        check("post_head", ch2(bus2.port_data, 1), 32'h0000_0055);
        bus2.port_ready = 2'b10;
        step();
        bus2.port_ready = 2'b00;
        check("post_latched", ch2(bus2.port_latched, 1), 32'h0000_0055);
        check("post_alone", bus2.empty, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
